imm_decode_stage: RTL and testbench

- Pipelined, parametrised immediate generator for the RV32I decode path.
- Covers every RV32I immediate format (I, S, B, U, J); sign-extends to XLEN.
- Sits between fetch and execute, with valid/ready handshakes on both sides.
- A 2-entry output buffer absorbs execute backpressure without a combinational ready path.
- Flags unsupported opcodes and counts them.

---
 rtl/imm_pkg.sv | 35 +++
 rtl/imm_fmt_decode.sv | 61 ++++++
 rtl/imm_decode_stage.sv | 147 ++++++++++++++
 tb/tb_imm_decode_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the RV32I immediate decode stage: opcode values,
// immediate format encodings and the output-buffer FSM states.
package imm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Immediate format reported alongside each decoded entry; 6 is unused.
  typedef enum logic [2:0] {
    IMM_R    = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_NONE = 3'd7
  } imm_type_e;

  // Occupancy of the 2-entry output buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/imm_fmt_decode.sv
// Purely combinational RV32I immediate extractor. Builds a 32-bit
// sign-correct immediate per format, then sign-extends it to XLEN.
module imm_fmt_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instruction,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_type,
  output logic            o_illegal
);

  logic [31:0] w_imm32;
  imm_type_e   w_type;

  // Select format from the opcode; unknown opcodes yield a zero immediate.
  always_comb begin
    w_imm32   = '0;
    w_type    = IMM_NONE;
    o_illegal = 1'b0;
    case (i_instruction[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: begin
        w_imm32 = {{20{i_instruction[31]}}, i_instruction[31:20]};
        w_type  = IMM_I;
      end
      OP_STORE: begin
        w_imm32 = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
        w_type  = IMM_S;
      end
      OP_BRANCH: begin
        w_imm32 = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                   i_instruction[30:25], i_instruction[11:8], 1'b0};
        w_type  = IMM_B;
      end
      OP_LUI, OP_AUIPC: begin
        w_imm32 = {i_instruction[31:12], 12'b0};
        w_type  = IMM_U;
      end
      OP_JAL: begin
        w_imm32 = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                   i_instruction[20], i_instruction[30:21], 1'b0};
        w_type  = IMM_J;
      end
      OP_REG: begin
        w_imm32 = '0;
        w_type  = IMM_R;
      end
      default: begin
        w_imm32   = '0;
        w_type    = IMM_NONE;
        o_illegal = 1'b1;
      end
    endcase
  end

  // Size cast of a signed value replicates bit 31 into bits XLEN-1:32.
  assign o_imm      = XLEN'($signed(w_imm32));
  assign o_imm_type = w_type;

endmodule

// File: rtl/imm_decode_stage.sv
// Decode-path immediate stage: decodes on the input side, holds results in
// a head/skid output buffer so execute backpressure never reaches in_ready
// combinationally, and counts accepted illegal opcodes with saturation.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_instruction,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [XLEN-1:0]  o_imm_out,
  output logic [2:0]       o_imm_type,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  state_e            r_state;
  state_e            w_next_state;
  logic              r_in_ready;

  logic              w_accept;
  logic              w_drain;
  logic              w_load_head;
  logic              w_load_skid;
  logic              w_head_from_skid;

  logic [XLEN-1:0]   w_dec_imm;
  logic [2:0]        w_dec_type;
  logic              w_dec_illegal;

  logic [XLEN-1:0]   r_head_imm;
  logic [2:0]        r_head_type;
  logic              r_head_illegal;
  logic [XLEN-1:0]   r_skid_imm;
  logic [2:0]        r_skid_type;
  logic              r_skid_illegal;

  logic [CNT_W-1:0]  r_cnt;

  imm_fmt_decode #(
    .XLEN(XLEN)
  ) u_fmt_decode (
    .i_instruction(i_instruction),
    .o_imm        (w_dec_imm),
    .o_imm_type   (w_dec_type),
    .o_illegal    (w_dec_illegal)
  );

  assign w_accept    = i_in_valid && r_in_ready;
  assign o_out_valid = (r_state != ST_EMPTY);
  assign w_drain     = o_out_valid && i_out_ready;

  // State register; in_ready is registered alongside it from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != ST_TWO);
    end
  end

  // Next-state and buffer-steering decisions from accept/drain.
  always_comb begin
    w_next_state     = r_state;
    w_load_head      = 1'b0;
    w_load_skid      = 1'b0;
    w_head_from_skid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_next_state = ST_ONE;
          w_load_head  = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && !w_drain) begin
          w_next_state = ST_TWO;
          w_load_skid  = 1'b1;
        end else if (!w_accept && w_drain) begin
          w_next_state = ST_EMPTY;
        end else if (w_accept && w_drain) begin
          w_load_head  = 1'b1;
        end
      end
      ST_TWO: begin
        if (w_drain) begin
          w_next_state     = ST_ONE;
          w_head_from_skid = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_EMPTY;
      end
    endcase
  end

  // Head and skid entry storage; head only changes on load or skid promotion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head_imm     <= '0;
      r_head_type    <= IMM_NONE;
      r_head_illegal <= 1'b0;
      r_skid_imm     <= '0;
      r_skid_type    <= IMM_NONE;
      r_skid_illegal <= 1'b0;
    end else begin
      if (w_load_head) begin
        r_head_imm     <= w_dec_imm;
        r_head_type    <= w_dec_type;
        r_head_illegal <= w_dec_illegal;
      end else if (w_head_from_skid) begin
        r_head_imm     <= r_skid_imm;
        r_head_type    <= r_skid_type;
        r_head_illegal <= r_skid_illegal;
      end
      if (w_load_skid) begin
        r_skid_imm     <= w_dec_imm;
        r_skid_type    <= w_dec_type;
        r_skid_illegal <= w_dec_illegal;
      end
    end
  end

  // Saturating count of illegal instructions taken in on the input side.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_accept && w_dec_illegal && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_in_ready    = r_in_ready;
  assign o_imm_out     = r_head_imm;
  assign o_imm_type    = r_head_type;
  assign o_illegal     = r_head_illegal;
  assign o_illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed testbench for imm_decode_stage: format sweep at XLEN=32 and 64,
// backpressure, full-rate burst, mid-stream reset and counter saturation.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic [31:0] instruction;
  logic        outReady;

  logic        inReady, outValid, illegal;
  logic [31:0] immOut;
  logic [2:0]  immType;
  logic [15:0] illegalCnt;

  logic        inReady64, outValid64, illegal64;
  logic [63:0] immOut64;
  logic [2:0]  immType64;
  logic [15:0] illegalCnt64;

  logic        satValid;
  logic [31:0] satInstr;
  logic        satOutReady;
  logic        satInReady, satOutValid, satIllegal;
  logic [31:0] satImm;
  logic [2:0]  satType;
  logic [1:0]  satCnt;

  int compareCount = 0;
  int failCount    = 0;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(inValid), .o_in_ready(inReady),
    .i_instruction(instruction), .o_out_valid(outValid), .i_out_ready(outReady),
    .o_imm_out(immOut), .o_imm_type(immType), .o_illegal(illegal),
    .o_illegal_cnt(illegalCnt)
  );

  imm_decode_stage #(.XLEN(64), .CNT_W(16)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(inValid), .o_in_ready(inReady64),
    .i_instruction(instruction), .o_out_valid(outValid64), .i_out_ready(outReady),
    .o_imm_out(immOut64), .o_imm_type(immType64), .o_illegal(illegal64),
    .o_illegal_cnt(illegalCnt64)
  );

  imm_decode_stage #(.XLEN(32), .CNT_W(2)) dutSat (
    .i_clk(clk), .i_rst(rst), .i_in_valid(satValid), .o_in_ready(satInReady),
    .i_instruction(satInstr), .o_out_valid(satOutValid), .i_out_ready(satOutReady),
    .o_imm_out(satImm), .o_imm_type(satType), .o_illegal(satIllegal),
    .o_illegal_cnt(satCnt)
  );

  // Format sweep vectors with hand-computed expectations.
  logic [31:0] sweepWord [7] = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3,
                                 32'h123450B7, 32'h0010006F, 32'h002081B3,
                                 32'h0000007F};
  logic [63:0] sweepImm32 [7] = '{64'hFFFFFFFF, 64'h8, 64'hFFFFFFFC,
                                  64'h12345000, 64'h800, 64'h0, 64'h0};
  logic [63:0] sweepImm64 [7] = '{64'hFFFFFFFFFFFFFFFF, 64'h8, 64'hFFFFFFFFFFFFFFFC,
                                  64'h12345000, 64'h800, 64'h0, 64'h0};
  logic [2:0]  sweepType [7]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd7};
  logic        sweepIll [7]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  // Compare one observed value against its expectation and log any failure.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    compareCount++;
    assert (actual === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive the shared input handshake signals.
  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic ready);
    inValid     = valid;
    instruction = instr;
    outReady    = ready;
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    satValid    = 1'b0;
    satInstr    = 32'h0;
    satOutReady = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick;
    tick;

    checkOutput("rst_out_valid", 64'(outValid), 64'(0));
    checkOutput("rst_in_ready", 64'(inReady), 64'(1));
    checkOutput("rst_imm_out", 64'(immOut), 64'(0));
    checkOutput("rst_imm_type", 64'(immType), 64'(7));
    checkOutput("rst_illegal", 64'(illegal), 64'(0));
    checkOutput("rst_illegal_cnt", 64'(illegalCnt), 64'(0));
    checkOutput("rst64_out_valid", 64'(outValid64), 64'(0));
    checkOutput("rst64_in_ready", 64'(inReady64), 64'(1));
    checkOutput("rst64_illegal_cnt", 64'(illegalCnt64), 64'(0));
    checkOutput("rst_sat_out_valid", 64'(satOutValid), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, sweepWord[i], 1'b1);
      tick;
      checkOutput($sformatf("sweep%0d_out_valid", i), 64'(outValid), 64'(1));
      checkOutput($sformatf("sweep%0d_imm", i), 64'(immOut), sweepImm32[i]);
      checkOutput($sformatf("sweep%0d_type", i), 64'(immType), 64'(sweepType[i]));
      checkOutput($sformatf("sweep%0d_illegal", i), 64'(illegal), 64'(sweepIll[i]));
      checkOutput($sformatf("sweep%0d_cnt", i), 64'(illegalCnt), 64'((i == 6) ? 1 : 0));
      checkOutput($sformatf("sweep64_%0d_imm", i), immOut64, sweepImm64[i]);
      checkOutput($sformatf("sweep64_%0d_type", i), 64'(immType64), 64'(sweepType[i]));
      checkOutput($sformatf("sweep64_%0d_illegal", i), 64'(illegal64), 64'(sweepIll[i]));
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick;
    checkOutput("sweep_drained", 64'(outValid), 64'(0));
    checkOutput("sweep64_drained", 64'(outValid64), 64'(0));

    applyStimulus(1'b1, 32'h00100093, 1'b0);
    tick;
    checkOutput("bp1_out_valid", 64'(outValid), 64'(1));
    checkOutput("bp1_in_ready", 64'(inReady), 64'(1));
    checkOutput("bp1_imm", 64'(immOut), 64'(1));
    applyStimulus(1'b1, 32'h00200093, 1'b0);
    tick;
    checkOutput("bp2_in_ready_low", 64'(inReady), 64'(0));
    checkOutput("bp2_imm_stable", 64'(immOut), 64'(1));
    checkOutput("bp64_in_ready_low", 64'(inReady64), 64'(0));
    applyStimulus(1'b1, 32'h00300093, 1'b0);
    tick;
    checkOutput("bp3_in_ready_low", 64'(inReady), 64'(0));
    checkOutput("bp3_imm_stable", 64'(immOut), 64'(1));
    checkOutput("bp3_type_stable", 64'(immType), 64'(1));
    tick;
    checkOutput("bp4_out_valid", 64'(outValid), 64'(1));
    checkOutput("bp4_imm_stable", 64'(immOut), 64'(1));
    applyStimulus(1'b1, 32'h00300093, 1'b1);
    tick;
    checkOutput("bp5_imm", 64'(immOut), 64'(2));
    checkOutput("bp5_in_ready", 64'(inReady), 64'(1));
    tick;
    checkOutput("bp6_imm", 64'(immOut), 64'(3));
    applyStimulus(1'b1, 32'h00400093, 1'b1);
    tick;
    checkOutput("bp7_imm", 64'(immOut), 64'(4));
    applyStimulus(1'b1, 32'h00500093, 1'b1);
    tick;
    checkOutput("bp8_imm", 64'(immOut), 64'(5));
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick;
    checkOutput("bp_drained", 64'(outValid), 64'(0));

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h00A00093 + (32'(i) << 20), 1'b1);
      tick;
      checkOutput($sformatf("burst%0d_imm", i), 64'(immOut), 64'(10 + i));
      checkOutput($sformatf("burst%0d_in_ready", i), 64'(inReady), 64'(1));
      checkOutput($sformatf("burst%0d_out_valid", i), 64'(outValid), 64'(1));
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick;
    checkOutput("burst_drained", 64'(outValid), 64'(0));

    applyStimulus(1'b1, 32'h0000007F, 1'b0);
    tick;
    checkOutput("mid_cnt_two", 64'(illegalCnt), 64'(2));
    applyStimulus(1'b1, 32'h00100093, 1'b0);
    tick;
    checkOutput("mid_full", 64'(inReady), 64'(0));
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick;
    checkOutput("mid_rst_out_valid", 64'(outValid), 64'(0));
    checkOutput("mid_rst_in_ready", 64'(inReady), 64'(1));
    checkOutput("mid_rst_cnt", 64'(illegalCnt), 64'(0));
    checkOutput("mid_rst_type", 64'(immType), 64'(7));
    checkOutput("mid_rst_illegal", 64'(illegal), 64'(0));
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick;
    checkOutput("mid_no_stale1", 64'(outValid), 64'(0));
    tick;
    checkOutput("mid_no_stale2", 64'(outValid), 64'(0));

    satValid    = 1'b1;
    satInstr    = 32'h0000007F;
    satOutReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      checkOutput($sformatf("sat%0d_cnt", i), 64'(satCnt), 64'((i < 3) ? i + 1 : 3));
      checkOutput($sformatf("sat%0d_illegal", i), 64'(satIllegal), 64'(1));
      checkOutput($sformatf("sat%0d_type", i), 64'(satType), 64'(7));
      checkOutput($sformatf("sat%0d_imm", i), 64'(satImm), 64'(0));
      checkOutput($sformatf("sat%0d_in_ready", i), 64'(satInReady), 64'(1));
    end
    satValid = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
